matrix_row_packer: RTL and testbench
====================================

# matrix_row_packer

Collects a row-serial stream of matrix rows (one row of `COL_IN` elements per handshake) and assembles `ROW_IN` rows into one flat, row-major matrix word. It sits directly upstream of the combinational transpose stage in the attention datapath. It converts a valid/ready row stream into a held, full-matrix bus with its own valid/ready handshake.

## Interface
- `DATA_WIDTH`, 16, element width in bits
- `ROW_IN`, 8, rows per matrix (≥1)
- `COL_IN`, 4, elements per row (≥1)

Clock and reset are decided: one clock, reset asynchronous and active-low.
- `clk`  in  1  sole clock, all state on rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `in_valid`  in  1  row word valid
- `in_ready`  out  1  packer can accept a row this cycle
- `in_row`  in  `DATA_WIDTH*COL_IN`  one row; element j at bits `[DATA_WIDTH*(j+1)-1 : DATA_WIDTH*j]`
- `in_last`  in  1  sender marks final row of a matrix
- `out_valid`  out  1  complete matrix held on `out_mat`
- `out_ready`  in  1  consumer accepts matrix
- `out_mat`  out  `DATA_WIDTH*ROW_IN*COL_IN`  element (i,j) at bits `[DATA_WIDTH*(i*COL_IN+j+1)-1 : DATA_WIDTH*(i*COL_IN+j)]`
- `err`  out  1  sticky `in_last` framing error

## Operation
- Row accept = `in_valid && in_ready`. Accepted rows are stored into row slots 0, 1, … `ROW_IN-1` in order; the first row after reset or after a completed matrix is row 0.
- The row counter has width `max(1,$clog2(ROW_IN))`. It wraps to 0 on acceptance of row `ROW_IN-1`, and the matrix is then complete.
- Without double buffering, there are two states:
  - FILL: `in_ready=1`, `out_valid=0`.
  - FULL: `in_ready=0`, `out_valid=1`.
  - FILL→FULL when the last row is accepted. FULL→FILL on `out_valid && out_ready`.
- Row count alone defines matrix boundaries. `in_last` is checked only:
  - `in_last=1` on a row other than `ROW_IN-1`, or `in_last=0` on row `ROW_IN-1`, sets `err`.
  - The row is still stored and counting continues unchanged.
  - `err` clears only on reset.
- `out_mat` is stable and unchanged for as long as `out_valid=1`.
- `in_ready` depends only on registered state, never combinationally on `out_ready` or `in_valid`.
- `in_row` is ignored when `in_valid=0` or `in_ready=0`.

## Timing
- Reset (async assert): `in_ready=0`, `out_valid=0`, `out_mat=0`, `err=0`, row counter 0, all banks empty. Any partial matrix in progress is discarded.
- First rising edge after `rst_n` deasserts: `in_ready=1`.
- Latency: `out_valid` rises on the cycle after the edge that accepts row `ROW_IN-1`.
- Completion handshake: the edge where `out_valid && out_ready` holds drops `out_valid`. Without double buffering, `in_ready` rises in that same next cycle.
- Throughput without double buffering: one matrix per `ROW_IN+1` cycles when both sides always hold valid/ready.
- `ROW_IN=1`: every accepted row is a complete matrix and goes straight to FULL.
- `out_ready` while `out_valid=0` has no effect.
- `err` is set on the cycle after the offending accept.

## Configuration
- Macro: `MATRIX_ROW_PACKER_DOUBLE_BUF_EN`.
- Defined: two matrix banks, one fill bank and one output bank, with a 2-entry occupancy count.
  - `in_ready = (occupancy < 2)`.
  - The next matrix fills while the previous one is held on `out_mat`.
  - On a matrix completion and an output handshake in the same edge, the completed bank becomes the output bank next cycle, so `out_valid` stays 1 with new data.
  - Sustained throughput is one matrix per `ROW_IN` cycles.
  - Matrices emerge in acceptance order.
- Undefined: single bank, FILL/FULL behaviour as above.

## Test plan
- Reset, then 8 rows with row i = elements {4i+3, 4i+2, 4i+1, 4i} and `in_last` on row 7 → `out_valid` on the cycle after row 7; element (i,j) = 4i+j; `err=0`.
- `out_ready=0` for 10 cycles after completion → `out_mat` is unchanged and `out_valid` held. Without the macro, `in_ready=0` throughout; with the macro, `in_ready=1` until the second matrix completes, then 0.
- `in_last=1` on row 3 → `err=1` from the next cycle and stays 1; the matrix still completes after row 7 with correct data.
- `rst_n` pulsed low after 5 rows → all outputs return to reset values. The next 8 rows form a clean matrix with its first row at slot 0.
- Back-to-back matrices with `out_ready=1` and `in_valid=1` constantly → period of 9 cycles without the macro, 8 cycles with it; data order preserved.
- `in_valid` toggling randomly while `in_ready=0` → no rows are stored and the row counter is unchanged.

Source files
------------

// File: rtl/matrix_row_packer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | matrix_row_packer                                                        |
// | Packs ROW_IN serial rows of COL_IN elements into one row-major matrix    |
// | word with valid/ready on both sides.                                     |
// | Option macro: MATRIX_ROW_PACKER_DOUBLE_BUF_EN (fill/output bank pair).   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module matrix_row_packer #(
  parameter int DATA_WIDTH = 16,
  parameter int ROW_IN     = 8,
  parameter int COL_IN     = 4
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [DATA_WIDTH*COL_IN-1:0]         in_row,
  input  logic                                 in_last,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [DATA_WIDTH*ROW_IN*COL_IN-1:0]  out_mat,
  output logic                                 err
);

  localparam int ROW_W = DATA_WIDTH * COL_IN;
  localparam int CNT_W = (ROW_IN > 1) ? $clog2(ROW_IN) : 1;
  localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(ROW_IN - 1);
`ifdef MATRIX_ROW_PACKER_DOUBLE_BUF_EN
  localparam logic [1:0] OCC_MAX = 2'd2;
`else
  localparam logic [1:0] OCC_MAX = 2'd1;
`endif

  typedef enum logic [0:0] {
    S_INIT = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [1:0]       occ_q;
  logic [1:0]       occ_d;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             err_q;
  logic             accept;
  logic             complete;
  logic             pop;

  assign accept   = in_valid && in_ready_q;
  assign complete = accept && (cnt_q == LAST_ROW);
  assign pop      = out_valid_q && out_ready;
  // Occupancy counts completed matrices not yet handed to the consumer.
  assign occ_d    = occ_q + {1'b0, complete} - {1'b0, pop};

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign err       = err_q;

`ifdef MATRIX_ROW_PACKER_DOUBLE_BUF_EN
  logic [ROW_W-1:0] bank_q [2][ROW_IN];
  logic             wr_sel_q;
  logic             rd_sel_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < 2; b++) begin
        for (int r = 0; r < ROW_IN; r++) begin
          bank_q[b][r] <= '0;
        end
      end
    end else if (accept) begin
      bank_q[wr_sel_q][cnt_q] <= in_row;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_sel_q <= 1'b0;
      rd_sel_q <= 1'b0;
    end else begin
      if (complete) wr_sel_q <= ~wr_sel_q;
      if (pop)      rd_sel_q <= ~rd_sel_q;
    end
  end

  for (genvar r = 0; r < ROW_IN; r++) begin : g_out_row
    assign out_mat[r*ROW_W +: ROW_W] = bank_q[rd_sel_q][r];
  end
`else
  logic [ROW_W-1:0] bank_q [ROW_IN];

  // The single bank is only written while empty, so it is stable whenever out_valid is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < ROW_IN; r++) begin
        bank_q[r] <= '0;
      end
    end else if (accept) begin
      bank_q[cnt_q] <= in_row;
    end
  end

  for (genvar r = 0; r < ROW_IN; r++) begin : g_out_row
    assign out_mat[r*ROW_W +: ROW_W] = bank_q[r];
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_INIT;
      cnt_q       <= '0;
      occ_q       <= 2'd0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      case (state_q)
        S_INIT: begin
          in_ready_q <= 1'b1;
          state_q    <= S_RUN;
        end
        S_RUN: begin
          if (accept) begin
            cnt_q <= complete ? '0 : cnt_q + CNT_W'(1);
            // Framing is by count only; a mismatched in_last just flags it.
            if (in_last != complete) err_q <= 1'b1;
          end
          occ_q       <= occ_d;
          in_ready_q  <= (occ_d < OCC_MAX);
          out_valid_q <= (occ_d != 2'd0);
        end
        default: begin
          state_q <= S_INIT;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_matrix_row_packer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_matrix_row_packer                                                     |
// | Directed scoreboard bench for matrix_row_packer (either bank option).    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_matrix_row_packer;

  localparam int DW    = 16;
  localparam int RI    = 8;
  localparam int CI    = 4;
  localparam int ROW_W = DW * CI;
  localparam int MAT_W = DW * RI * CI;
  localparam int BOUND = 60;
`ifdef MATRIX_ROW_PACKER_DOUBLE_BUF_EN
  localparam int   EXP_PERIOD = 8;
  localparam logic HOLD_RDY   = 1'b1;
`else
  localparam int   EXP_PERIOD = 9;
  localparam logic HOLD_RDY   = 1'b0;
`endif

  logic             clk       = 1'b0;
  logic             rst_n     = 1'b0;
  logic             in_valid  = 1'b0;
  logic             in_last   = 1'b0;
  logic             out_ready = 1'b0;
  logic [ROW_W-1:0] in_row    = '0;
  logic             in_ready;
  logic             out_valid;
  logic             err;
  logic [MAT_W-1:0] out_mat;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  logic [MAT_W-1:0] sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  matrix_row_packer #(.DATA_WIDTH(DW), .ROW_IN(RI), .COL_IN(CI)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_row(in_row), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_mat(out_mat), .err(err)
  );

  function automatic logic [ROW_W-1:0] mk_row(input int base, input int i);
    logic [ROW_W-1:0] r;
    for (int j = 0; j < CI; j++) r[DW*j +: DW] = DW'(base + 4*i + j);
    return r;
  endfunction

  function automatic logic [MAT_W-1:0] mk_mat(input int base);
    logic [MAT_W-1:0] m;
    for (int i = 0; i < RI; i++) m[ROW_W*i +: ROW_W] = mk_row(base, i);
    return m;
  endfunction

  task automatic check(input string tag, input logic [MAT_W-1:0] obs, input logic [MAT_W-1:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Holds the row on the bus until an edge sees in_ready high.
  task automatic send_row(input logic [ROW_W-1:0] row, input logic last);
    logic rdy;
    int   n;
    n        = 0;
    in_valid = 1'b1;
    in_row   = row;
    in_last  = last;
    do begin
      rdy = in_ready;
      tick();
      n++;
    end while (!rdy && n < BOUND);
    if (!rdy) begin
      n_chk++;
      n_fail++;
      $display("FAIL send_row_timeout: in_ready observed 0 expected 1");
    end
  endtask

  task automatic send_matrix(input int base);
    sb.push_back(mk_mat(base));
    for (int i = 0; i < RI; i++) send_row(mk_row(base, i), i == RI - 1);
  endtask

  task automatic consume(input string tag);
    int n;
    n = 0;
    while (out_valid !== 1'b1 && n < BOUND) begin
      tick();
      n++;
    end
    check1({tag, "_valid"}, out_valid, 1'b1);
    if (sb.size() == 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s_sb: observed empty scoreboard expected pending matrix", tag);
    end else begin
      check(tag, out_mat, sb.pop_front());
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    int t[3];
    int got;

    // Reset values and first edge after release
    repeat (2) tick();
    check1("rst_in_ready", in_ready, 1'b0);
    check1("rst_out_valid", out_valid, 1'b0);
    check("rst_out_mat", out_mat, '0);
    check1("rst_err", err, 1'b0);
    rst_n = 1'b1;
    check1("rel_ready_pre", in_ready, 1'b0);
    tick();
    check1("rel_ready", in_ready, 1'b1);

    // Basic matrix and completion latency
    sb.push_back(mk_mat(0));
    for (int i = 0; i < RI; i++) begin
      send_row(mk_row(0, i), i == RI - 1);
      if (i == RI - 2) check1("lat_early", out_valid, 1'b0);
    end
    idle();
    check1("lat_valid", out_valid, 1'b1);
    check1("basic_err", err, 1'b0);

    // Hold with out_ready low; in_valid toggles while in_ready is low
    for (int k = 0; k < 10; k++) begin
      in_valid = (in_ready === 1'b0) ? 1'($urandom_range(0, 1)) : 1'b0;
      in_row   = {$urandom(), $urandom()};
      tick();
      check1("hold_valid", out_valid, 1'b1);
      check1("hold_ready", in_ready, HOLD_RDY);
      check("hold_mat", out_mat, sb[0]);
    end
    idle();
    consume("basic_mat");
    check1("pop_valid", out_valid, 1'b0);
    check1("pop_ready", in_ready, 1'b1);

    // in_last framing error on row 3
    sb.push_back(mk_mat(100));
    for (int i = 0; i < RI; i++) begin
      send_row(mk_row(100, i), (i == 3) || (i == RI - 1));
      if (i == 2) check1("err_before", err, 1'b0);
      if (i == 3) check1("err_set", err, 1'b1);
    end
    idle();
    consume("err_mat");
    check1("err_sticky", err, 1'b1);

    // Asynchronous reset after a partial matrix
    for (int i = 0; i < 5; i++) send_row(mk_row(200, i), 1'b0);
    idle();
    check1("partial_no_valid", out_valid, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check1("arst_in_ready", in_ready, 1'b0);
    check1("arst_out_valid", out_valid, 1'b0);
    check("arst_out_mat", out_mat, '0);
    check1("arst_err", err, 1'b0);
    tick();
    rst_n = 1'b1;
    tick();
    check1("arst_rel_ready", in_ready, 1'b1);
    send_matrix(300);
    idle();
    consume("after_rst_mat");
    check1("after_rst_err", err, 1'b0);

    // Back-to-back matrices, both sides always willing
    got = 0;
    fork
      begin
        for (int m = 0; m < 3; m++) send_matrix(1000 + 100*m);
        idle();
      end
      begin
        out_ready = 1'b1;
        for (int n = 0; n < 4*BOUND && got < 3; n++) begin
          if (out_valid === 1'b1) begin
            if (sb.size() == 0) begin
              n_chk++;
              n_fail++;
              $display("FAIL tput_sb: observed empty scoreboard expected pending matrix");
            end else begin
              check("tput_mat", out_mat, sb.pop_front());
            end
            t[got] = cyc;
            got++;
          end
          tick();
        end
        out_ready = 1'b0;
      end
    join
    check("tput_count", MAT_W'(got), MAT_W'(3));
    if (got == 3) begin
      check("tput_period1", MAT_W'(t[1] - t[0]), MAT_W'(EXP_PERIOD));
      check("tput_period2", MAT_W'(t[2] - t[1]), MAT_W'(EXP_PERIOD));
    end
    check1("tput_err", err, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
